// File: rtl/companion_pkg.sv
// companion_pkg
// Shared definitions for the companion blocks (status, mood, display):
// the mood encoding, its width and the default stat ceiling.
// No ports; imported with "import companion_pkg::*;".
package companion_pkg;

   localparam int MOOD_W           = 3;
   localparam int STAT_MAX_DEFAULT = 100;

   typedef enum logic [MOOD_W-1:0] {
      MOOD_HAPPY   = 3'd0,
      MOOD_CONTENT = 3'd1,
      MOOD_HUNGRY  = 3'd2,
      MOOD_DIRTY   = 3'd3,
      MOOD_SAD     = 3'd4,
      MOOD_SICK    = 3'd5,
      MOOD_DEAD    = 3'd6
   } mood_e;

   // Moods that drive the blinking attention LED.
   function automatic logic mood_alerting(input mood_e m);
      return (m == MOOD_HUNGRY) || (m == MOOD_DIRTY) ||
             (m == MOOD_SAD)    || (m == MOOD_SICK);
   endfunction

endpackage

// File: rtl/companion_tick_gen.sv
// companion_tick_gen
// One-cycle strobe every CLOCK_FREQ clock cycles (1 Hz at the nominal clock).
// The phase counter wraps at CLOCK_FREQ-1; CLOCK_FREQ=1 strobes every cycle.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous, active-low reset (clears the phase)
//   tick out  one-cycle strobe
module companion_tick_gen #(
   parameter int CLOCK_FREQ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int               CNT_W    = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_FREQ - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                cnt <= '0;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/companion_mood.sv
// companion_mood
// Classifies the four companion stats into one mood with hysteresis on the
// individual condition flags and a sickness-to-death timer. Three register
// stages: clamp inputs, update flags, update mood and LED outputs.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   health       in   stat from companion_status
//   happiness    in   stat from companion_status
//   clean        in   stat from companion_status
//   hunger       in   stat from companion_status (0 = full)
//   mood         out  mood code (companion_pkg::mood_e)
//   mood_changed out  one-cycle pulse when mood takes a new value
//   alert        out  attention LED
//   dead         out  high while mood is DEAD
module companion_mood
   import companion_pkg::*;
#(
   parameter int CLOCK_FREQ   = 50_000_000,
   parameter int DATA_W       = 32,
   parameter int STAT_MAX     = STAT_MAX_DEFAULT,
   parameter int LOW_THRESH   = 25,
   parameter int HIGH_THRESH  = 75,
   parameter int HYST         = 5,
   parameter int SICK_SECONDS = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] health,
   input  logic [DATA_W-1:0] happiness,
   input  logic [DATA_W-1:0] clean,
   input  logic [DATA_W-1:0] hunger,
   output logic [MOOD_W-1:0] mood,
   output logic              mood_changed,
   output logic              alert,
   output logic              dead
);

   localparam logic [DATA_W-1:0] STAT_MAX_V = DATA_W'(STAT_MAX);
   localparam logic [DATA_W-1:0] LOW_SET_V  = DATA_W'(LOW_THRESH);
   localparam logic [DATA_W-1:0] LOW_CLR_V  = DATA_W'(LOW_THRESH + HYST);
   localparam logic [DATA_W-1:0] HIGH_SET_V = DATA_W'(HIGH_THRESH);
   localparam logic [DATA_W-1:0] HIGH_CLR_V = DATA_W'(HIGH_THRESH - HYST);
   localparam int                SICK_W     = $clog2(SICK_SECONDS + 1);
   localparam logic [SICK_W-1:0] SICK_MAX   = SICK_W'(SICK_SECONDS);

   function automatic logic [DATA_W-1:0] clamp_stat(input logic [DATA_W-1:0] v);
      return (v > STAT_MAX_V) ? STAT_MAX_V : v;
   endfunction

   // Flag raised by a low value, released only once the value climbs
   // HYST above the threshold; in between it holds.
   function automatic logic hyst_low(input logic cur, input logic [DATA_W-1:0] v);
      if (v < LOW_SET_V)   return 1'b1;
      if (v >= LOW_CLR_V)  return 1'b0;
      return cur;
   endfunction

   function automatic logic hyst_high(input logic cur, input logic [DATA_W-1:0] v);
      if (v > HIGH_SET_V)  return 1'b1;
      if (v <= HIGH_CLR_V) return 1'b0;
      return cur;
   endfunction

   logic tick;

   companion_tick_gen #(
      .CLOCK_FREQ (CLOCK_FREQ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // ---- stage 1: registered, clamped stats ----
   logic [DATA_W-1:0] health_p0, happiness_p0, clean_p0, hunger_p0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         health_p0    <= STAT_MAX_V;
         happiness_p0 <= STAT_MAX_V;
         clean_p0     <= STAT_MAX_V;
         hunger_p0    <= '0;
      end else begin
         health_p0    <= clamp_stat(health);
         happiness_p0 <= clamp_stat(happiness);
         clean_p0     <= clamp_stat(clean);
         hunger_p0    <= clamp_stat(hunger);
      end
   end

   // ---- stage 2: condition flags ----
   // thriving_p1 resets high so it agrees with the reset stats (full
   // health and happiness); otherwise mood would dip to CONTENT after reset.
   logic low_health_p1, dirty_p1, sad_p1, hungry_p1, zero_p1, thriving_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         low_health_p1 <= 1'b0;
         dirty_p1      <= 1'b0;
         sad_p1        <= 1'b0;
         hungry_p1     <= 1'b0;
         zero_p1       <= 1'b0;
         thriving_p1   <= 1'b1;
      end else begin
         low_health_p1 <= hyst_low(low_health_p1, health_p0);
         dirty_p1      <= hyst_low(dirty_p1, clean_p0);
         sad_p1        <= hyst_low(sad_p1, happiness_p0);
         hungry_p1     <= hyst_high(hungry_p1, hunger_p0);
         zero_p1       <= (health_p0 == '0);
         thriving_p1   <= (happiness_p0 >= HIGH_SET_V) && (health_p0 >= HIGH_SET_V);
      end
   end

   // ---- stage 3: mood, sick timer and LED outputs ----
   mood_e             mood_p2, mood_nxt;
   logic              changed_p2, alert_p2, dead_p2, alert_nxt;
   logic [SICK_W-1:0] sick_cnt_p2;

   always_comb begin
      mood_nxt = MOOD_CONTENT;
      if ((mood_p2 == MOOD_DEAD) || zero_p1 || (sick_cnt_p2 == SICK_MAX))
         mood_nxt = MOOD_DEAD;
      else if (low_health_p1) mood_nxt = MOOD_SICK;
      else if (hungry_p1)     mood_nxt = MOOD_HUNGRY;
      else if (dirty_p1)      mood_nxt = MOOD_DIRTY;
      else if (sad_p1)        mood_nxt = MOOD_SAD;
      else if (thriving_p1)   mood_nxt = MOOD_HAPPY;

      // Entering any alert mood (including from another alert mood)
      // restarts the blink phase at 1.
      alert_nxt = 1'b0;
      if (mood_nxt == MOOD_DEAD)
         alert_nxt = 1'b1;
      else if (mood_alerting(mood_nxt))
         alert_nxt = (mood_nxt != mood_p2) ? 1'b1 : (tick ? ~alert_p2 : alert_p2);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mood_p2     <= MOOD_HAPPY;
         changed_p2  <= 1'b0;
         alert_p2    <= 1'b0;
         dead_p2     <= 1'b0;
         sick_cnt_p2 <= '0;
      end else begin
         mood_p2    <= mood_nxt;
         changed_p2 <= (mood_nxt != mood_p2);
         alert_p2   <= alert_nxt;
         dead_p2    <= (mood_nxt == MOOD_DEAD);
         if (mood_p2 != MOOD_SICK)
            sick_cnt_p2 <= '0;
         else if (tick && (sick_cnt_p2 != SICK_MAX))
            sick_cnt_p2 <= sick_cnt_p2 + 1'b1;
      end
   end

   assign mood         = mood_p2;
   assign mood_changed = changed_p2;
   assign alert        = alert_p2;
   assign dead         = dead_p2;

endmodule

// File: tb/tb_companion_mood.sv
module tb_companion_mood;
   import companion_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] health = 32'd100, happiness = 32'd100, clean = 32'd100, hunger = 32'd0;
   logic [2:0]  mood;
   logic        mood_changed, alert, dead;

   typedef struct packed {
      logic [63:0] tag;
      logic [2:0]  mood;
      logic        chg;
      logic        alert;
      logic        dead;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] tag = "init";
   int          n_vec  = 0;
   int          n_miss = 0;

   always #5 clk = ~clk;

   companion_mood #(
      .CLOCK_FREQ (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .health       (health),
      .happiness    (happiness),
      .clean        (clean),
      .hunger       (hunger),
      .mood         (mood),
      .mood_changed (mood_changed),
      .alert        (alert),
      .dead         (dead)
   );

   // Apply one vector at the falling edge; the expected outputs describe
   // the state just after the following rising edge.
   task automatic v(input logic r, input logic [31:0] h, hp, c, hu,
                    input logic [2:0] m, input logic mc, a, d);
      @(negedge clk);
      rst       = r;
      health    = h;
      happiness = hp;
      clean     = c;
      hunger    = hu;
      exp_q.push_back({tag, m, mc, a, d});
   endtask

   task automatic good(input logic [2:0] m, input logic mc, a, d);
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd0, m, mc, a, d);
   endtask

   task automatic do_reset();
      tag = "rst";
      repeat (2) v(1'b0, 32'd100, 32'd100, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      repeat (3) good(MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
   endtask

   // health=20 from HAPPY: two pipeline edges, then n cycles observed in SICK.
   task automatic sick_run(input int n);
      repeat (2) v(1'b1, 32'd20, 32'd100, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++)
         v(1'b1, 32'd20, 32'd100, 32'd100, 32'd0, MOOD_SICK, i == 0, (i % 2) == 0, 1'b0);
   endtask

   // Monitor: one expected entry per cycle, sampled 1 time unit after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({mood, mood_changed, alert, dead} !== {e.mood, e.chg, e.alert, e.dead}) begin
               n_miss++;
               $display("FAIL %0s: got mood=%0d changed=%0b alert=%0b dead=%0b, want mood=%0d changed=%0b alert=%0b dead=%0b",
                        e.tag, mood, mood_changed, alert, dead, e.mood, e.chg, e.alert, e.dead);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d entries pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset with arbitrary inputs, then release with full stats
      tag = "reset";
      repeat (3) v(1'b0, 32'd5, 32'd5, 32'd5, 32'd90, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      tag = "release";
      repeat (3) good(MOOD_HAPPY, 1'b0, 1'b0, 1'b0);

      // 2. hunger rises, hysteresis hold, recovery
      tag = "hungry";
      repeat (2) v(1'b1, 32'd100, 32'd100, 32'd100, 32'd80, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         v(1'b1, 32'd100, 32'd100, 32'd100, 32'd80, MOOD_HUNGRY, i == 0, (i % 2) == 0, 1'b0);
      tag = "hyst";
      for (int i = 0; i < 4; i++)
         v(1'b1, 32'd100, 32'd100, 32'd100, 32'd72, MOOD_HUNGRY, 1'b0, (i % 2) == 0, 1'b0);
      tag = "recover";
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd70, MOOD_HUNGRY, 1'b0, 1'b1, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd70, MOOD_HUNGRY, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd70, MOOD_HAPPY,  1'b1, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd70, MOOD_HAPPY,  1'b0, 1'b0, 1'b0);

      // 3. priority and alert-to-alert transition
      tag = "prio";
      repeat (2) v(1'b1, 32'd100, 32'd100, 32'd10, 32'd80, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd10, 32'd80, MOOD_HUNGRY, 1'b1, 1'b1, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd10, 32'd80, MOOD_HUNGRY, 1'b0, 1'b0, 1'b0);
      tag = "dirty";
      v(1'b1, 32'd100, 32'd100, 32'd10, 32'd0, MOOD_HUNGRY, 1'b0, 1'b1, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd10, 32'd0, MOOD_HUNGRY, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd10, 32'd0, MOOD_DIRTY,  1'b1, 1'b1, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd10, 32'd0, MOOD_DIRTY,  1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd10, 32'd0, MOOD_DIRTY,  1'b0, 1'b1, 1'b0);
      tag = "clean";
      v(1'b1, 32'd100, 32'd100, 32'd30, 32'd0, MOOD_DIRTY, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd30, 32'd0, MOOD_DIRTY, 1'b0, 1'b1, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd30, 32'd0, MOOD_HAPPY, 1'b1, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd30, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      tag = "content";
      repeat (2) v(1'b1, 32'd100, 32'd60, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd60, 32'd100, 32'd0, MOOD_CONTENT, 1'b1, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd60, 32'd100, 32'd0, MOOD_CONTENT, 1'b0, 1'b0, 1'b0);
      tag = "sad";
      repeat (2) v(1'b1, 32'd100, 32'd10, 32'd100, 32'd0, MOOD_CONTENT, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd10, 32'd100, 32'd0, MOOD_SAD, 1'b1, 1'b1, 1'b0);
      v(1'b1, 32'd100, 32'd10, 32'd100, 32'd0, MOOD_SAD, 1'b0, 1'b0, 1'b0);
      tag = "unsad";
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd0, MOOD_SAD,   1'b0, 1'b1, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd0, MOOD_SAD,   1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd0, MOOD_HAPPY, 1'b1, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd100, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);

      // 4. sick for 10 ticks, then sticky death
      tag = "sick";
      sick_run(11);
      tag = "dead";
      v(1'b1, 32'd20, 32'd100, 32'd100, 32'd0, MOOD_DEAD, 1'b1, 1'b1, 1'b1);
      v(1'b1, 32'd20, 32'd100, 32'd100, 32'd0, MOOD_DEAD, 1'b0, 1'b1, 1'b1);
      tag = "sticky";
      repeat (4) good(MOOD_DEAD, 1'b0, 1'b1, 1'b1);
      do_reset();

      // 5. zero health goes straight to DEAD; clamp of a huge stat
      tag = "zero";
      repeat (2) v(1'b1, 32'd0, 32'd100, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd0, 32'd100, 32'd100, 32'd0, MOOD_DEAD, 1'b1, 1'b1, 1'b1);
      repeat (2) v(1'b1, 32'd0, 32'd100, 32'd100, 32'd0, MOOD_DEAD, 1'b0, 1'b1, 1'b1);
      do_reset();
      tag = "content2";
      repeat (2) v(1'b1, 32'd100, 32'd60, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd60, 32'd100, 32'd0, MOOD_CONTENT, 1'b1, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'd60, 32'd100, 32'd0, MOOD_CONTENT, 1'b0, 1'b0, 1'b0);
      tag = "clamp";
      repeat (2) v(1'b1, 32'd100, 32'hFFFF_FFFF, 32'd100, 32'd0, MOOD_CONTENT, 1'b0, 1'b0, 1'b0);
      v(1'b1, 32'd100, 32'hFFFF_FFFF, 32'd100, 32'd0, MOOD_HAPPY, 1'b1, 1'b0, 1'b0);
      repeat (2) v(1'b1, 32'd100, 32'hFFFF_FFFF, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);

      // 6. reset after 5 ticks in SICK restarts the full timer
      tag = "midsick";
      sick_run(6);
      tag = "midrst";
      repeat (2) v(1'b0, 32'd20, 32'd100, 32'd100, 32'd0, MOOD_HAPPY, 1'b0, 1'b0, 1'b0);
      tag = "resick";
      sick_run(11);
      tag = "redead";
      v(1'b1, 32'd20, 32'd100, 32'd100, 32'd0, MOOD_DEAD, 1'b1, 1'b1, 1'b1);
      v(1'b1, 32'd20, 32'd100, 32'd100, 32'd0, MOOD_DEAD, 1'b0, 1'b1, 1'b1);

      // drain the scoreboard
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/companion_mood.md
Name: companion_mood

Overview:
Downstream consumer of the companion stat block. Takes the four 32-bit stats (health, happiness, clean, hunger) and classifies them into a single mood state, with hysteresis and a sickness-to-death timer. Drives the display/LED layer: mood code, a blinking alert and a sticky dead flag. Uses the same 1 Hz time base convention (CLOCK_FREQ cycles per second).

Parameters:
CLOCK_FREQ, 50_000_000, clk cycles per second; value 1 gives a tick every cycle.
STAT_MAX, 100, saturation ceiling; any input above it is treated as STAT_MAX.
LOW_THRESH, 25, health, clean and happiness below this raise their flag.
HIGH_THRESH, 75, hunger above this raises the hungry flag; the happy test uses >= on happiness and health.
HYST, 5, hysteresis band for clearing flags.
SICK_SECONDS, 10, whole ticks spent in SICK before DEAD.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
health  in  32  from companion_status
happiness  in  32  from companion_status
clean  in  32  from companion_status
hunger  in  32  from companion_status (0 = full, rising = hungrier)
mood  out  3  0 HAPPY, 1 CONTENT, 2 HUNGRY, 3 DIRTY, 4 SAD, 5 SICK, 6 DEAD
mood_changed  out  1  one-cycle pulse when mood takes a new value
alert  out  1  attention LED
dead  out  1  high while mood is DEAD

Behaviour:
- Reset (rst low, async): the stat registers load health, happiness and clean with STAT_MAX and hunger with 0. All flags clear, mood=HAPPY, mood_changed=0, alert=0, dead=0, sick timer=0, tick counter=0.
- Stage 1: inputs are registered and clamped to STAT_MAX.
- Stage 2, flag set/clear rules (flags change only at this stage):
  - low_health: set when health < LOW_THRESH; cleared when health >= LOW_THRESH+HYST.
  - dirty: set when clean < LOW_THRESH; cleared when clean >= LOW_THRESH+HYST.
  - sad: set when happiness < LOW_THRESH; cleared when happiness >= LOW_THRESH+HYST.
  - hungry: set when hunger > HIGH_THRESH; cleared when hunger <= HIGH_THRESH-HYST.
  - zero flag: registered health == 0.
- Stage 3, mood register, next state by priority:
  - DEAD if already DEAD (sticky until reset), or zero flag, or the sick timer has reached SICK_SECONDS.
  - else SICK if low_health.
  - else HUNGRY, then DIRTY, then SAD.
  - else HAPPY if registered happiness >= HIGH_THRESH and health >= HIGH_THRESH.
  - else CONTENT.
- Latency: an input stable before edge k is registered at k, updates flags at k+1, and updates mood at k+2. mood_changed is high for exactly the cycle after k+2 only if the value differs.
- Tick: a 1 Hz strobe, one cycle wide, every CLOCK_FREQ cycles; the counter wraps at CLOCK_FREQ-1.
- Sick timer:
  - Counts ticks while mood==SICK.
  - Clears on any edge where mood != SICK.
  - Saturates at SICK_SECONDS.
  - Width is clog2(SICK_SECONDS+1).
- alert:
  - 0 in HAPPY or CONTENT.
  - In HUNGRY, DIRTY, SAD or SICK: forced to 1 on the entering edge, then toggles on every tick.
  - Constant 1 in DEAD.
- dead = (mood==DEAD), registered.
- Simultaneous events: health reaching 0 on the same edge the sick timer expires gives one transition to DEAD and one mood_changed pulse. A transition between two alert states restarts alert at 1.
- Reset mid-operation: everything clears immediately, including the partial sick timer and the tick phase. After release, a low stat must re-traverse the full 2-cycle pipeline.

Decomposition:
- companion_pkg holds the mood encoding constants (MOOD_HAPPY..MOOD_DEAD), the 3-bit mood width and the default STAT_MAX. The same package is shared with companion_status and the display.
- One sub-module, companion_tick_gen: parameter CLOCK_FREQ; ports clk, rst, tick. It is reusable by companion_status.

Test Plan:
All scenarios use CLOCK_FREQ=1 (tick every cycle).
1. Reset: hold rst=0 with arbitrary inputs -> mood=0, alert=0, dead=0, mood_changed=0. Release with stats 100/100/100/0 -> mood stays 0 and no pulse.
2. hunger 0->80 -> mood=2 two edges after registration, one-cycle mood_changed, alert 1,0,1,... per cycle. Then hunger=72 -> stays 2 (hysteresis). Then hunger=70 -> mood=0 and alert=0.
3. Priority: hunger=80 and clean=10 together -> mood=2. Then hunger=0 -> mood=3. Then clean=30 -> mood=0. Then happiness=60 -> mood=1.
4. health=20 -> mood=5. Hold for 10 ticks -> mood=6, dead=1, alert constant 1. Then health=100 -> stays 6 until rst.
5. health=0 from HAPPY -> mood=6 directly (skips 5) with a single mood_changed pulse. Separately, happiness=0xFFFF_FFFF -> clamped to 100, mood=0.
6. Reset mid-SICK: pulse rst after 5 ticks in SICK. Release with health=20 held -> SICK re-entered, DEAD only after a further full 10 ticks.
